rule90_unwind: RTL



---
 rtl/rule90_pkg.sv | 22 ++
 rtl/rule90_unwind_chunk.sv | 40 ++++
 rtl/rule90_unwind.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rule90_pkg.sv
// Shared types and helpers for the Rule 90 unwind engine.
// rule90_fwd is the forward step, used by the bench and by checkers.
package rule90_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 512;
    localparam int CHUNK_DEF = 32;
    localparam int STEPW_DEF = 16;
    // Clocks per generation at the default geometry
    localparam int P = WIDTH_DEF / (2 * CHUNK_DEF);

    // One forward generation with null boundaries: next[i] = s[i-1] ^ s[i+1]
    function automatic logic [WIDTH_DEF-1:0] rule90_fwd(input logic [WIDTH_DEF-1:0] s);
        return (s << 1) ^ (s >> 1);
    endfunction

endpackage

// File: rtl/rule90_unwind_chunk.sv
// Resolves one CHUNK-wide slice of both inverse prefix-XOR chains.
// Odd results run upward from even_bits[0]; even results run downward from odd_bits[CHUNK-1].
module rule90_unwind_chunk
    import rule90_pkg::*;
#(
    parameter int CHUNK = 32
) (
    input  logic [CHUNK-1:0] even_bits,
    input  logic [CHUNK-1:0] odd_bits,
    input  logic             acc_odd_in,
    input  logic             acc_even_in,
    output logic [CHUNK-1:0] odd_res,
    output logic [CHUNK-1:0] even_res,
    output logic             acc_odd_out,
    output logic             acc_even_out
);

    logic run_odd;
    logic run_even;

    // Two running parities, one per chain direction
    always_comb begin
        odd_res  = {CHUNK{1'b0}};
        even_res = {CHUNK{1'b0}};
        run_odd  = acc_odd_in;
        run_even = acc_even_in;
        for (int j = 0; j < CHUNK; j++) begin
            run_odd    = run_odd ^ even_bits[j];
            odd_res[j] = run_odd;
        end
        for (int j = CHUNK - 1; j >= 0; j--) begin
            run_even    = run_even ^ odd_bits[j];
            even_res[j] = run_even;
        end
    end

    assign acc_odd_out  = odd_res[CHUNK-1];
    assign acc_even_out = even_res[0];

endmodule

// File: rtl/rule90_unwind.sv
// Serial inverse of the null-boundary Rule 90 automaton: recovers the state
// `steps` generations back, resolving CHUNK bit-pairs of each chain per clock.
module rule90_unwind
    import rule90_pkg::*;
#(
    parameter int WIDTH = 512,
    parameter int CHUNK = 32,
    parameter int STEPW = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] data,
    input  logic             start,
    input  logic [STEPW-1:0] steps,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] q
);

    localparam int HALF = WIDTH / 2;
    localparam int NP   = WIDTH / (2 * CHUNK);
    localparam int CIW  = (NP > 1) ? $clog2(NP) : 1;

    state_t           state;
    state_t           state_next;
    logic [STEPW-1:0] gen_left;
    logic [CIW-1:0]   chunk_idx;
    logic             acc_odd;
    logic             acc_even;
    logic [HALF-1:0]  r_odd;
    logic [HALF-1:0]  r_even;

    logic [HALF-1:0]  q_even_s;
    logic [HALF-1:0]  q_odd_s;
    logic [HALF-1:0]  r_odd_s;
    logic [HALF-1:0]  r_even_s;
    logic [WIDTH-1:0] r_full_s;
    logic [CHUNK-1:0] even_in_s;
    logic [CHUNK-1:0] odd_in_s;
    logic [CHUNK-1:0] odd_res_s;
    logic [CHUNK-1:0] even_res_s;
    logic             acc_odd_nx_s;
    logic             acc_even_nx_s;
    logic             last_chunk_s;
    int               obase_s;
    int               ebase_s;

    assign last_chunk_s = (chunk_idx == CIW'(NP - 1));

    // Split q into even/odd lanes, pick this cycle's slices, merge results into the shadow
    always_comb begin
        q_even_s = {HALF{1'b0}};
        q_odd_s  = {HALF{1'b0}};
        for (int k = 0; k < HALF; k++) begin
            q_even_s[k] = q[2*k];
            q_odd_s[k]  = q[2*k+1];
        end
        // Odd chain walks up from the bottom while the even chain walks down from the top
        obase_s   = int'(chunk_idx) * CHUNK;
        ebase_s   = (NP - 1 - int'(chunk_idx)) * CHUNK;
        even_in_s = q_even_s[obase_s +: CHUNK];
        odd_in_s  = q_odd_s[ebase_s +: CHUNK];
        r_odd_s   = r_odd;
        r_even_s  = r_even;
        r_odd_s[obase_s +: CHUNK]  = odd_res_s;
        r_even_s[ebase_s +: CHUNK] = even_res_s;
        r_full_s  = {WIDTH{1'b0}};
        for (int k = 0; k < HALF; k++) begin
            r_full_s[2*k]   = r_even_s[k];
            r_full_s[2*k+1] = r_odd_s[k];
        end
    end

    rule90_unwind_chunk #(.CHUNK(CHUNK)) u_chunk (
        .even_bits    (even_in_s),
        .odd_bits     (odd_in_s),
        .acc_odd_in   (acc_odd),
        .acc_even_in  (acc_even),
        .odd_res      (odd_res_s),
        .even_res     (even_res_s),
        .acc_odd_out  (acc_odd_nx_s),
        .acc_even_out (acc_even_nx_s)
    );

    // Next-state logic; load overrides everything and returns to IDLE
    always_comb begin
        state_next = state;
        if (load) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_next = (steps != {STEPW{1'b0}}) ? RUN : DONE;
                    end else begin
                        state_next = IDLE;
                    end
                end
                RUN: begin
                    if (last_chunk_s && (gen_left == STEPW'(1))) begin
                        state_next = DONE;
                    end else begin
                        state_next = RUN;
                    end
                end
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // State, counters, chain accumulators, shadow register and q
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gen_left  <= {STEPW{1'b0}};
            chunk_idx <= {CIW{1'b0}};
            acc_odd   <= 1'b0;
            acc_even  <= 1'b0;
            r_odd     <= {HALF{1'b0}};
            r_even    <= {HALF{1'b0}};
            q         <= {WIDTH{1'b0}};
        end else begin
            state <= state_next;
            if (load) begin
                q <= data;
            end else if (state == IDLE && start) begin
                gen_left  <= steps;
                chunk_idx <= {CIW{1'b0}};
                acc_odd   <= 1'b0;
                acc_even  <= 1'b0;
            end else if (state == RUN) begin
                r_odd  <= r_odd_s;
                r_even <= r_even_s;
                if (last_chunk_s) begin
                    q         <= r_full_s;
                    gen_left  <= gen_left - STEPW'(1);
                    chunk_idx <= {CIW{1'b0}};
                    acc_odd   <= 1'b0;
                    acc_even  <= 1'b0;
                end else begin
                    chunk_idx <= chunk_idx + CIW'(1);
                    acc_odd   <= acc_odd_nx_s;
                    acc_even  <= acc_even_nx_s;
                end
            end
        end
    end

    assign busy = (state == RUN);
    assign done = (state == DONE);

endmodule
